hilo_wb_stage: RTL and testbench
================================

// Module: hilo_wb_stage
// PURPOSE
//  Consumer end of the EX-stage control bundle: executes mult/multu on an iterative
//  shift-add multiplier into HI/LO and drives pipeline stall while it runs.
//  Owns GPIO out register and GPIO in synchronizer.
//  Selects write-back source (ALU/HI/LO/GPIO) and dest reg; registers EX->WB.
// PARAMETERS
//  WIDTH      32  datapath width; HI/LO each WIDTH, product 2*WIDTH
//  SYNC_STAGES 2  flops in gpio_in synchronizer (>=2)
// PORTS
//  clk            in   1     single clock, all state on posedge
//  rst            in   1     synchronous, active-high reset
//  alu_op_EX      in   4     4'b0110 = mult (signed), 4'b0111 = multu; others ignored here
//  enhilo_EX      in   1     mult/multu in EX
//  regsel_EX      in   2     0 ALU, 1 HI (or GPIO when GPIO_IN), 2 LO, 3 reserved->ALU
//  regwrite_EX    in   1     instruction writes a GPR
//  rdrt_EX        in   1     1: dest = rt (I-type), 0: dest = rd
//  GPIO_OUT       in   1     srl-shamt0 GPIO write enable
//  GPIO_IN        in   1     sra-shamt0 GPIO read enable
//  rt_addr_EX     in   5     instr[20:16]
//  rd_addr_EX     in   5     instr[15:11]
//  rs_data_EX     in   WIDTH multiplicand
//  rt_data_EX     in   WIDTH multiplier
//  alu_result_EX  in   WIDTH ALU output
//  gpio_in        in   WIDTH asynchronous pins
//  stall_EX       out  1     hold fetch/decode/EX inputs stable
//  gpio_out       out  WIDTH GPIO output register
//  regwrite_WB    out  1     registered GPR write enable
//  regdest_WB     out  5     registered GPR write address
//  writedata_WB   out  WIDTH registered GPR write data
//  hi_o, lo_o     out  WIDTH current HI/LO (debug/forwarding)
// BEHAVIOUR
//  Reset: HI=LO=0, gpio_out=0, sync flops 0, WB regs 0, FSM IDLE, stall_EX=0.
//  Reset mid-multiply aborts; HI/LO still cleared.
//  Mult FSM IDLE/BUSY/DONE:
//   IDLE & enhilo_EX: latch |rs|,|rt| (signed) or raw (multu), result sign; cnt=0;
//     -> BUSY; stall_EX=1 combinationally this cycle.
//   BUSY: one shift-add step/cycle; stall_EX=1; at cnt==WIDTH-1 -> DONE.
//   DONE: negate 2*WIDTH product if signs differ; {HI,LO} <= product;
//     stall_EX=0 (mult retires); -> IDLE.
//   Latency: WIDTH+2 cycles in EX (34 @32). Back-to-back mult accepted cycle after DONE.
//  Inputs must be stable while stall_EX=1; WB regs take a bubble (regwrite_WB<=0).
//  mfhi/mflo immediately after mult reads new HI/LO (written end of DONE).
//  WB mux, sampled only when stall_EX=0:
//   regsel 1 & GPIO_IN -> synced gpio_in; regsel 1 -> HI; 2 -> LO; 0/3 -> alu_result_EX.
//  regdest = rdrt_EX ? rt_addr_EX : rd_addr_EX.
//  regwrite_WB <= regwrite_EX & (regdest != 0); writes to $0 suppressed.
//  GPIO_OUT & !stall_EX: gpio_out <= alu_result_EX (holds otherwise).
//  gpio_in passes SYNC_STAGES flops; read value is SYNC_STAGES cycles old.
//  enhilo_EX with alu_op not 0110/0111: treated as multu.
// CONFIGURATION
//  HILO_FAST_MULT_EN defined: single-cycle combinational multiply; {HI,LO} written
//  end of accept cycle; stall_EX tied 0; FSM and mult_iter not instantiated.
//  Undefined: iterative FSM above.
// STRUCTURE
//  mips_ctrl_pkg: regsel_t enum (REGSEL_ALU/HI/LO), ALU_OP_MULT/MULTU constants,
//  mult_state_t enum (IDLE/BUSY/DONE).
//  Sub-module mult_iter: unsigned WIDTHxWIDTH shift-add core with start/done;
//  sign handling and HI/LO writeback stay in hilo_wb_stage.
// TESTING
//  1. mult rs=0xFFFFFFFF(-1) rt=1 -> stall 33 cycles high, HI=LO=0xFFFFFFFF.
//  2. multu rs=0xFFFFFFFF rt=2 -> HI=0x00000001, LO=0xFFFFFFFE; then mfhi rd=5
//     next cycle -> regwrite_WB=1, regdest_WB=5, writedata_WB=0x00000001.
//  3. mult 0x80000000*0x80000000 -> HI=0x40000000, LO=0; reset asserted in BUSY
//     cycle 10 -> stall_EX=0, HI=LO=0 next cycle.
//  4. GPIO_OUT=1 alu_result=0xA5A5A5A5 -> gpio_out=0xA5A5A5A5 next cycle;
//     gpio_in=0x1234, GPIO_IN=1 regsel=1 rd=7 after 2 cycles -> writedata_WB=0x1234.
//  5. addi rdrt=1 rt=0 regwrite=1 -> regwrite_WB=0; rdrt=1 rt=9 -> regdest_WB=9.
//  6. HILO_FAST_MULT_EN: mult 3*-4 -> stall_EX never 1, HI=0xFFFFFFFF LO=0xFFFFFFF4.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared control types for the EX/WB boundary: write-back source select,
// multiply opcodes and the iterative multiplier's state encoding.
package mips_ctrl_pkg;

  typedef enum logic [1:0] {
    REGSEL_ALU = 2'd0,
    REGSEL_HI  = 2'd1,
    REGSEL_LO  = 2'd2
  } regsel_t;

  localparam logic [3:0] ALU_OP_MULT  = 4'b0110;
  localparam logic [3:0] ALU_OP_MULTU = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  // Only the signed opcode gets sign handling; any other opcode arriving with
  // the HI/LO enable is treated as unsigned.
  function automatic logic isSignedMult(input logic [3:0] op);
    return op == ALU_OP_MULT;
  endfunction

endpackage

// File: rtl/hilo_wb_stage_mult_iter.sv
// mult_iter: unsigned WIDTH x WIDTH shift-add multiplier core.
// i_start loads the operands; one partial product is accumulated per cycle,
// and o_last flags the cycle in which the final step is taken, so the product
// is complete from the following cycle on.
module mult_iter
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_start,
  input  logic [WIDTH-1:0]     i_a,
  input  logic [WIDTH-1:0]     i_b,
  output logic [2*WIDTH-1:0]   o_product,
  output logic                 o_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic [2*WIDTH-1:0] r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mplier;
  logic [CW-1:0]      r_cnt;
  logic               r_run;
  logic [2*WIDTH-1:0] w_addend;

  assign w_addend  = r_mplier[0] ? r_mcand : '0;
  assign o_product = r_prod;
  assign o_last    = r_run && (r_cnt == LAST_STEP);

  // Load on start, then add the shifted multiplicand whenever the current multiplier bit is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand  <= '0;
      r_prod   <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_run    <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_prod   <= '0;
      r_mplier <= i_b;
      r_cnt    <= '0;
      r_run    <= 1'b1;
    end else if (r_run) begin
      r_prod   <= r_prod + w_addend;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
      if (r_cnt == LAST_STEP) begin
        r_run <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_wb_stage.sv
// hilo_wb_stage: executes mult/multu into HI/LO, owns the GPIO output register
// and the GPIO input synchronizer, and registers the EX->WB write-back bundle.
// Build option: HILO_FAST_MULT_EN selects a single-cycle combinational
// multiply with no stall; left undefined, an iterative FSM around mult_iter
// is used and stall_EX holds the pipeline while it runs.
module hilo_wb_stage
  import mips_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       alu_op_EX,
  input  logic             enhilo_EX,
  input  logic [1:0]       regsel_EX,
  input  logic             regwrite_EX,
  input  logic             rdrt_EX,
  input  logic             GPIO_OUT,
  input  logic             GPIO_IN,
  input  logic [4:0]       rt_addr_EX,
  input  logic [4:0]       rd_addr_EX,
  input  logic [WIDTH-1:0] rs_data_EX,
  input  logic [WIDTH-1:0] rt_data_EX,
  input  logic [WIDTH-1:0] alu_result_EX,
  input  logic [WIDTH-1:0] gpio_in,
  output logic             stall_EX,
  output logic [WIDTH-1:0] gpio_out,
  output logic             regwrite_WB,
  output logic [4:0]       regdest_WB,
  output logic [WIDTH-1:0] writedata_WB,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_gpioOut;
  logic [WIDTH-1:0] r_sync [SYNC_STAGES];
  logic             r_wbWrite;
  logic [4:0]       r_wbDest;
  logic [WIDTH-1:0] r_wbData;

  logic             w_stall;
  logic             w_signedOp;
  logic [4:0]       w_regdest;
  logic [WIDTH-1:0] w_wbData;

  assign w_signedOp = isSignedMult(alu_op_EX);

`ifdef HILO_FAST_MULT_EN

  logic [2*WIDTH-1:0] w_opA;
  logic [2*WIDTH-1:0] w_opB;
  logic [2*WIDTH-1:0] w_fastProd;

  // Extending to 2*WIDTH first makes the low 2*WIDTH product bits correct for both signednesses.
  assign w_opA      = w_signedOp ? {{WIDTH{rs_data_EX[WIDTH-1]}}, rs_data_EX} : {{WIDTH{1'b0}}, rs_data_EX};
  assign w_opB      = w_signedOp ? {{WIDTH{rt_data_EX[WIDTH-1]}}, rt_data_EX} : {{WIDTH{1'b0}}, rt_data_EX};
  assign w_fastProd = w_opA * w_opB;
  assign w_stall    = 1'b0;

  // HI/LO take the full product at the end of the cycle the multiply is in EX.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (enhilo_EX) begin
      {r_hi, r_lo} <= w_fastProd;
    end
  end

`else

  mult_state_t        r_state;
  mult_state_t        w_next;
  logic               r_negate;
  logic               w_start;
  logic               w_last;
  logic               w_writeHilo;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic [2*WIDTH-1:0] w_iterProd;
  logic [2*WIDTH-1:0] w_finalProd;

  // The core multiplies magnitudes; the most negative value maps onto itself, which reads correctly as unsigned.
  assign w_absA      = (w_signedOp && rs_data_EX[WIDTH-1]) ? -rs_data_EX : rs_data_EX;
  assign w_absB      = (w_signedOp && rt_data_EX[WIDTH-1]) ? -rt_data_EX : rt_data_EX;
  assign w_finalProd = r_negate ? -w_iterProd : w_iterProd;

  // Accept stalls immediately, BUSY stalls until the last step, DONE releases the stall and writes HI/LO.
  always_comb begin
    w_next      = r_state;
    w_start     = 1'b0;
    w_stall     = 1'b0;
    w_writeHilo = 1'b0;
    case (r_state)
      IDLE: begin
        if (enhilo_EX) begin
          w_start = 1'b1;
          w_stall = 1'b1;
          w_next  = BUSY;
        end
      end
      BUSY: begin
        w_stall = 1'b1;
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        w_writeHilo = 1'b1;
        w_next      = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  // Multiplier FSM state register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Result sign is captured at accept since the operands are only guaranteed stable while stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_negate <= 1'b0;
    end else if (w_start) begin
      r_negate <= w_signedOp && (rs_data_EX[WIDTH-1] ^ rt_data_EX[WIDTH-1]);
    end
  end

  // HI/LO are written at the end of DONE so an mfhi/mflo in the next cycle sees the new value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (w_writeHilo) begin
      {r_hi, r_lo} <= w_finalProd;
    end
  end

  mult_iter #(
    .WIDTH(WIDTH)
  ) u_multIter (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_start),
    .i_a      (w_absA),
    .i_b      (w_absB),
    .o_product(w_iterProd),
    .o_last   (w_last)
  );

`endif

  // Destination select and write-back source mux; GPIO read shares the HI select.
  always_comb begin
    w_regdest = rdrt_EX ? rt_addr_EX : rd_addr_EX;
    w_wbData  = alu_result_EX;
    case (regsel_t'(regsel_EX))
      REGSEL_HI: w_wbData = GPIO_IN ? r_sync[SYNC_STAGES-1] : r_hi;
      REGSEL_LO: w_wbData = r_lo;
      default:   w_wbData = alu_result_EX;
    endcase
  end

  // gpio_in crosses in through a plain flop chain; the last stage is what software reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  // GPIO output register only updates when the writing instruction actually retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpioOut <= '0;
    end else if (GPIO_OUT && !w_stall) begin
      r_gpioOut <= alu_result_EX;
    end
  end

  // EX->WB register; a stalled cycle becomes a bubble and writes to $0 are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wbWrite <= 1'b0;
      r_wbDest  <= '0;
      r_wbData  <= '0;
    end else if (w_stall) begin
      r_wbWrite <= 1'b0;
    end else begin
      r_wbWrite <= regwrite_EX && (w_regdest != 5'd0);
      r_wbDest  <= w_regdest;
      r_wbData  <= w_wbData;
    end
  end

  assign stall_EX     = w_stall;
  assign gpio_out     = r_gpioOut;
  assign regwrite_WB  = r_wbWrite;
  assign regdest_WB   = r_wbDest;
  assign writedata_WB = r_wbData;
  assign hi_o         = r_hi;
  assign lo_o         = r_lo;

endmodule

// File: tb/tb_hilo_wb_stage.sv
// Testbench for hilo_wb_stage: a cycle-level reference model of the stage is
// compared against the DUT on every falling edge, and directed scenarios add
// hand-computed literal expectations. Honours HILO_FAST_MULT_EN like the RTL.
module tb_hilo_wb_stage;

  localparam int W    = 32;
  localparam int SYNC = 2;

`ifdef HILO_FAST_MULT_EN
  localparam int MULT_STALLS = 0;
`else
  localparam int MULT_STALLS = W + 1;
`endif

  logic          clk;
  logic          rst;
  logic [3:0]    alu_op_EX;
  logic          enhilo_EX;
  logic [1:0]    regsel_EX;
  logic          regwrite_EX;
  logic          rdrt_EX;
  logic          GPIO_OUT;
  logic          GPIO_IN;
  logic [4:0]    rt_addr_EX;
  logic [4:0]    rd_addr_EX;
  logic [W-1:0]  rs_data_EX;
  logic [W-1:0]  rt_data_EX;
  logic [W-1:0]  alu_result_EX;
  logic [W-1:0]  gpio_in;
  logic          stall_EX;
  logic [W-1:0]  gpio_out;
  logic          regwrite_WB;
  logic [4:0]    regdest_WB;
  logic [W-1:0]  writedata_WB;
  logic [W-1:0]  hi_o;
  logic [W-1:0]  lo_o;

  int assertCount = 0;
  int failCount   = 0;
  bit checkEn     = 1'b0;

  hilo_wb_stage #(
    .WIDTH(W),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .alu_op_EX    (alu_op_EX),
    .enhilo_EX    (enhilo_EX),
    .regsel_EX    (regsel_EX),
    .regwrite_EX  (regwrite_EX),
    .rdrt_EX      (rdrt_EX),
    .GPIO_OUT     (GPIO_OUT),
    .GPIO_IN      (GPIO_IN),
    .rt_addr_EX   (rt_addr_EX),
    .rd_addr_EX   (rd_addr_EX),
    .rs_data_EX   (rs_data_EX),
    .rt_data_EX   (rt_data_EX),
    .alu_result_EX(alu_result_EX),
    .gpio_in      (gpio_in),
    .stall_EX     (stall_EX),
    .gpio_out     (gpio_out),
    .regwrite_WB  (regwrite_WB),
    .regdest_WB   (regdest_WB),
    .writedata_WB (writedata_WB),
    .hi_o         (hi_o),
    .lo_o         (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: architectural registers plus a count of cycles a multiply has spent in EX.
  logic [W-1:0]   mHi, mLo, mGpioOut, mWbData;
  logic           mWbWrite;
  logic [4:0]     mWbDest;
  logic [2*W-1:0] mPending;
  int             mPos;
  logic [W-1:0]   mHist[$];

  // Full product straight from integer arithmetic.
  function automatic logic [2*W-1:0] refProduct(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    if (op == 4'b0110) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // A multiply occupies EX for W+2 cycles; every one but the last holds the pipeline.
  function automatic logic expStall();
`ifdef HILO_FAST_MULT_EN
    return 1'b0;
`else
    if (mPos == 0) return enhilo_EX;
    return mPos <= W;
`endif
  endfunction

  task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Advance the model by one clock using the inputs presented during the cycle.
  always @(posedge clk) begin : modelProc
    logic         stallNow;
    logic [4:0]   dest;
    logic [W-1:0] data;
    if (rst) begin
      mHi = '0; mLo = '0; mGpioOut = '0;
      mWbWrite = 1'b0; mWbDest = '0; mWbData = '0;
      mPos = 0; mPending = '0;
      mHist = {};
      for (int i = 0; i < SYNC; i++) mHist.push_back('0);
    end else begin
      stallNow = expStall();
      dest = rdrt_EX ? rt_addr_EX : rd_addr_EX;
      if (regsel_EX == 2'd1)      data = GPIO_IN ? mHist[0] : mHi;
      else if (regsel_EX == 2'd2) data = mLo;
      else                        data = alu_result_EX;
      if (stallNow) begin
        mWbWrite = 1'b0;
      end else begin
        mWbWrite = regwrite_EX && (dest != 5'd0);
        mWbDest  = dest;
        mWbData  = data;
      end
      if (GPIO_OUT && !stallNow) mGpioOut = alu_result_EX;
`ifdef HILO_FAST_MULT_EN
      if (enhilo_EX) {mHi, mLo} = refProduct(alu_op_EX, rs_data_EX, rt_data_EX);
`else
      if (mPos == 0) begin
        if (enhilo_EX) begin
          mPending = refProduct(alu_op_EX, rs_data_EX, rt_data_EX);
          mPos = 1;
        end
      end else if (mPos <= W) begin
        mPos++;
      end else begin
        {mHi, mLo} = mPending;
        mPos = 0;
      end
`endif
      mHist.push_back(gpio_in);
      void'(mHist.pop_front());
    end
  end

  // Every falling edge after reset: all DUT outputs must match the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("cyc_stall_EX", W'(stall_EX), W'(expStall()));
      checkOutput("cyc_gpio_out", gpio_out, mGpioOut);
      checkOutput("cyc_regwrite_WB", W'(regwrite_WB), W'(mWbWrite));
      checkOutput("cyc_regdest_WB", W'(regdest_WB), W'(mWbDest));
      checkOutput("cyc_writedata_WB", writedata_WB, mWbData);
      checkOutput("cyc_hi", hi_o, mHi);
      checkOutput("cyc_lo", lo_o, mLo);
    end
  end

  task automatic idleInputs();
    alu_op_EX = '0; enhilo_EX = 1'b0; regsel_EX = '0; regwrite_EX = 1'b0;
    rdrt_EX = 1'b0; GPIO_OUT = 1'b0; GPIO_IN = 1'b0;
    rt_addr_EX = '0; rd_addr_EX = '0;
    rs_data_EX = '0; rt_data_EX = '0; alu_result_EX = '0;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Issue one multiply, hold it while stalled, return one cycle after it retires.
  task automatic applyStimulus(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b, output int stallCycles);
    bit finished;
    finished = 1'b0;
    alu_op_EX = op; rs_data_EX = a; rt_data_EX = b; enhilo_EX = 1'b1;
    stallCycles = 0;
    for (int i = 0; i < 100 && !finished; i++) begin
      #1;
      if (stall_EX === 1'b1) stallCycles++;
      else finished = 1'b1;
      nextCycle();
    end
    checkOutput("mult_completes", W'(finished), W'(1));
    idleInputs();
  endtask

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stimulus
    int stalls;
    idleInputs();
    gpio_in = '0;
    rst = 1'b1;
    nextCycle();
    checkEn = 1'b1;
    nextCycle();
    checkOutput("reset_stall", W'(stall_EX), W'(0));
    checkOutput("reset_hi", hi_o, '0);
    checkOutput("reset_wb_write", W'(regwrite_WB), W'(0));
    rst = 1'b0;
    nextCycle();

    $display("[TB] test 1: mult -1 * 1");
    applyStimulus(4'b0110, 32'hFFFF_FFFF, 32'h0000_0001, stalls);
    checkOutput("t1_stall_cycles", W'(stalls), W'(MULT_STALLS));
    checkOutput("t1_hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("t1_lo", lo_o, 32'hFFFF_FFFF);

    $display("[TB] test 2: multu 0xFFFFFFFF * 2, then mfhi $5");
    applyStimulus(4'b0111, 32'hFFFF_FFFF, 32'h0000_0002, stalls);
    regsel_EX = 2'd1; regwrite_EX = 1'b1; rd_addr_EX = 5'd5;
    checkOutput("t2_hi", hi_o, 32'h0000_0001);
    checkOutput("t2_lo", lo_o, 32'hFFFF_FFFE);
    nextCycle();
    checkOutput("t2_mfhi_write", W'(regwrite_WB), W'(1));
    checkOutput("t2_mfhi_dest", W'(regdest_WB), W'(5));
    checkOutput("t2_mfhi_data", writedata_WB, 32'h0000_0001);
    regsel_EX = 2'd2; rd_addr_EX = 5'd4;
    nextCycle();
    checkOutput("t2_mflo_data", writedata_WB, 32'hFFFF_FFFE);
    idleInputs();

    $display("[TB] test 3: mult 0x80000000^2, then reset mid-multiply");
    regwrite_EX = 1'b1; rd_addr_EX = 5'd3; alu_result_EX = 32'h0000_0077;
    applyStimulus(4'b0110, 32'h8000_0000, 32'h8000_0000, stalls);
    checkOutput("t3_hi", hi_o, 32'h4000_0000);
    checkOutput("t3_lo", lo_o, 32'h0000_0000);
    checkOutput("t3_retire_data", writedata_WB, 32'h0000_0077);
    alu_op_EX = 4'b0110; rs_data_EX = 32'd5; rt_data_EX = 32'd7; enhilo_EX = 1'b1;
    repeat (11) nextCycle();
    checkOutput("t3_busy_stall", W'(stall_EX), W'(MULT_STALLS > 0 ? 1 : 0));
    rst = 1'b1; enhilo_EX = 1'b0;
    nextCycle();
    checkOutput("t3_rst_stall", W'(stall_EX), W'(0));
    checkOutput("t3_rst_hi", hi_o, '0);
    checkOutput("t3_rst_lo", lo_o, '0);
    rst = 1'b0;
    idleInputs();
    nextCycle();

    $display("[TB] test 4: GPIO out and synchronized GPIO in");
    GPIO_OUT = 1'b1; alu_result_EX = 32'hA5A5_A5A5;
    nextCycle();
    checkOutput("t4_gpio_out", gpio_out, 32'hA5A5_A5A5);
    idleInputs();
    gpio_in = 32'h0000_1234;
    repeat (2) nextCycle();
    GPIO_IN = 1'b1; regsel_EX = 2'd1; regwrite_EX = 1'b1; rd_addr_EX = 5'd7;
    nextCycle();
    checkOutput("t4_gpio_in_data", writedata_WB, 32'h0000_1234);
    checkOutput("t4_gpio_in_dest", W'(regdest_WB), W'(7));
    idleInputs();

    $display("[TB] test 5: destination select and $0 suppression");
    rdrt_EX = 1'b1; rt_addr_EX = 5'd0; rd_addr_EX = 5'd12; regwrite_EX = 1'b1; alu_result_EX = 32'd42;
    nextCycle();
    checkOutput("t5_zero_write", W'(regwrite_WB), W'(0));
    rt_addr_EX = 5'd9;
    nextCycle();
    checkOutput("t5_rt_dest", W'(regdest_WB), W'(9));
    checkOutput("t5_rt_write", W'(regwrite_WB), W'(1));
    rdrt_EX = 1'b0; regsel_EX = 2'd3; alu_result_EX = 32'h0000_CAFE;
    nextCycle();
    checkOutput("t5_rd_dest", W'(regdest_WB), W'(12));
    checkOutput("t5_regsel3_data", writedata_WB, 32'h0000_CAFE);
    idleInputs();

    $display("[TB] test 6: mult 3 * -4, back-to-back multu, odd opcode as multu");
    applyStimulus(4'b0110, 32'd3, 32'hFFFF_FFFC, stalls);
    checkOutput("t6_stall_cycles", W'(stalls), W'(MULT_STALLS));
    checkOutput("t6_hi", hi_o, 32'hFFFF_FFFF);
    checkOutput("t6_lo", lo_o, 32'hFFFF_FFF4);
    applyStimulus(4'b0111, 32'd7, 32'd6, stalls);
    checkOutput("t6_b2b_hi", hi_o, 32'h0000_0000);
    checkOutput("t6_b2b_lo", lo_o, 32'd42);
    applyStimulus(4'b0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, stalls);
    checkOutput("t6_oddop_hi", hi_o, 32'hFFFF_FFFE);
    checkOutput("t6_oddop_lo", lo_o, 32'h0000_0001);

    repeat (3) nextCycle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
